wam_ctl: RTL and testbench
==========================

# wam_ctl

Game sequencer for the whack-a-mole core. Runs the round state machine (idle, countdown, play, over), holds the mole generator in clear outside play, and times the round. It qualifies key presses against live moles and forwards accepted hits to the generator. It also keeps the BCD score and miss count, and raises difficulty (`hrdn`) as the score grows. It sits between the debounced key inputs, the mole generator, and the display driver.

## Interface
Parameters:
- `GAME_SEC`, 30: play duration in seconds (1..63).
- `READY_SEC`, 3: countdown duration in seconds (1..15).
- `LVL_STEP`, 10: accepted hits per difficulty step (1..99).

Ports:
- `clk` in 1: single clock, same clock that drives the generator's state machine.
- `clr_n` in 1: asynchronous, active-low reset.
- `sec_tick` in 1: one-cycle strobe, once per second.
- `start` in 1: one-cycle start/restart pulse.
- `hrdn_sel` in 4: base difficulty, latched on leaving IDLE/OVER.
- `keys` in 8: debounced key levels, 1 = pressed.
- `holes` in 8: mole present per hole, from the generator.
- `gen_clr` out 1: 1 = generator held in clear.
- `hrdn` out 4: difficulty to the generator.
- `hit_ok` out 8: accepted hit per hole, held until the mole clears.
- `score` out 8: two BCD digits, 00..99.
- `miss` out 8: two BCD digits, 00..99.
- `time_left` out 6: seconds remaining in the current phase.
- `state` out 2: 0 IDLE, 1 READY, 2 PLAY, 3 OVER.

## Operation
- States and transitions:
  - IDLE: on `start`, go to READY.
  - READY: on the `sec_tick` that takes `time_left` from 1 to 0, go to PLAY.
  - PLAY: on the `sec_tick` that takes `time_left` from 1 to 0, go to OVER.
  - OVER: on `start`, go to READY. `start` has no effect in READY or PLAY.
- Entering READY:
  - `time_left`=READY_SEC.
  - `score`=`miss`=0.
  - `base`<=`hrdn_sel`.
- Entering PLAY: `time_left`=GAME_SEC.
- IDLE and OVER hold `time_left`; OVER keeps the final `score` and `miss`.
- `gen_clr`=1 in every state except PLAY.
- Key edge detect: `kedge = keys & ~keys_q`, with `keys_q` registered every cycle in all states.
- Hits are evaluated only in PLAY:
  - `acc = kedge & holes & ~hit_ok`.
  - `bad = kedge & ~holes`.
  - A key edge on a hole already in `hit_ok` is ignored, neither hit nor miss.
- `hit_ok[i]`:
  - set when `acc[i]`.
  - cleared when `holes[i]`=0.
  - all bits cleared when not in PLAY.
  - set has priority over clear in the same cycle.
- `score` adds popcount(`acc`) (0..8) in BCD and saturates at 99. `miss` does the same with popcount(`bad`).
- Level counter: counts accepted hits modulo LVL_STEP and increments `lvl` (4 bits) on wrap. A multi-hit cycle may cross at most one step; excess wraps normally.
- `hrdn` = min(`base` + `lvl`, 15), registered. `lvl` clears on entering READY.
- `sec_tick` and a state transition in the same cycle: the transition uses the pre-tick `time_left`. Ticks in IDLE/OVER are ignored.

## Timing
- Reset values:
  - `state`=IDLE, `gen_clr`=1, `hrdn`=0, `hit_ok`=0.
  - `score`=0, `miss`=0, `time_left`=0.
  - `keys_q`=0, `lvl`=0, `base`=0.
- All outputs are registered.
- `gen_clr` deasserts the cycle after the final READY tick and reasserts the cycle after the final PLAY tick.
- `hit_ok` goes high 1 cycle after the key edge, and `score` updates in the same cycle. `hrdn` updates 1 cycle after `score` crosses a step.
- Reset mid-round returns to IDLE immediately, and `gen_clr` is asserted asynchronously.
- Keys held through reset do not create an edge after reset release, because `keys_q` tracks `keys` from the first clock.

## Structure
- Shared package `wam_pkg` holds:
  - state encodings `ST_IDLE`, `ST_READY`, `ST_PLAY`, `ST_OVER`.
  - BCD saturation limit 8'h99.
  - `HRDN_MAX`=15.
- Sub-module `wam_bcd_acc` is instantiated twice (score and miss): an 8-bit BCD accumulator with clear, add 0..8, and saturation at 99.

## Test plan
- Reset, then `start` and 3 ticks: READY with `time_left` 3→2→1, then PLAY with `time_left`=30 and `gen_clr` 1→0 on the cycle after the third tick.
- In PLAY with `holes`=8'h05, rising edge `keys`=8'h07: `hit_ok`=8'h05, `score`=01 +2 → 03, `miss`=01. `hit_ok[0]` clears the cycle after `holes[0]` falls.
- Score at 98 and an edge accepting 3 moles: `score`=99, then further hits keep 99.
- `hrdn_sel`=13, LVL_STEP=10, 20 accepted hits: `hrdn` 13→14→15, then stays 15 after 30 hits.
- 30 ticks in PLAY: OVER with `gen_clr`=1, `score` held, `hit_ok`=0, and key edges ignored. `start` then goes to READY with `score`=00.
- `clr_n` low mid-PLAY with `keys`=8'hFF held: IDLE, all outputs at reset values. After release, `start` plus 3 ticks gives no spurious hit or miss.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared encodings and helpers for the whack-a-mole game sequencer.
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] BCD_SAT  = 8'h99;
  localparam logic [3:0] HRDN_MAX = 4'd15;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/wam_bcd_acc.sv
// Two-digit BCD accumulator: adds 0..8 per cycle, saturates at 99, sync clear wins.
// One cycle from i_add to o_val; no backpressure.
module wam_bcd_acc
  import wam_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       i_clr,
  input  logic [3:0] i_add,
  output logic [7:0] o_val
);

  logic [7:0] r_val;
  logic [6:0] w_bin;
  logic [7:0] w_sum;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [7:0] w_nxt;

  // Add in binary and convert back; the sum never exceeds 107 so 7 bits carry it.
  always_comb begin
    w_bin  = 7'(r_val[7:4]) * 7'd10 + 7'(r_val[3:0]);
    w_sum  = {1'b0, w_bin} + {4'd0, i_add};
    w_tens = 4'(w_sum[6:0] / 7'd10);
    w_ones = 4'(w_sum[6:0] % 7'd10);
    w_nxt  = (w_sum > 8'd99) ? BCD_SAT : {w_tens, w_ones};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_val <= 8'h00;
    end else if (i_clr) begin
      r_val <= 8'h00;
    end else begin
      r_val <= w_nxt;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/wam_ctl.sv
// Round sequencer: IDLE/READY/PLAY/OVER, hit qualification, BCD score/miss, difficulty ramp.
// All outputs registered, one cycle from inputs; no backpressure (strobe/level inputs only).
module wam_ctl
  import wam_pkg::*;
#(
  parameter int GAME_SEC  = 30,
  parameter int READY_SEC = 3,
  parameter int LVL_STEP  = 10
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       sec_tick,
  input  logic       start,
  input  logic [3:0] hrdn_sel,
  input  logic [7:0] keys,
  input  logic [7:0] holes,
  output logic       gen_clr,
  output logic [3:0] hrdn,
  output logic [7:0] hit_ok,
  output logic [7:0] score,
  output logic [7:0] miss,
  output logic [5:0] time_left,
  output logic [1:0] state
);

  localparam logic [5:0] READY_T = 6'(READY_SEC);
  localparam logic [5:0] GAME_T  = 6'(GAME_SEC);
  localparam logic [6:0] STEP_W  = 7'(LVL_STEP);

  state_t     r_state;
  logic [5:0] r_time;
  logic       r_gen_clr;
  logic [7:0] r_keys_q;
  logic [7:0] r_hit_ok;
  logic [3:0] r_base;
  logic [3:0] r_lvl;
  logic [6:0] r_lvl_cnt;
  logic [3:0] r_hrdn;

  logic       w_in_play;
  logic       w_play_end;
  logic       w_to_ready;
  logic [7:0] w_kedge;
  logic [7:0] w_acc;
  logic [7:0] w_bad;
  logic [3:0] w_acc_n;
  logic [3:0] w_bad_n;
  logic [6:0] w_lvl_sum;
  logic       w_lvl_wrap;
  logic [4:0] w_hsum;

  assign w_in_play  = (r_state == ST_PLAY);
  assign w_play_end = w_in_play && sec_tick && (r_time <= 6'd1);
  assign w_to_ready = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && start;

  assign w_kedge = keys & ~r_keys_q;
  assign w_acc   = w_in_play ? (w_kedge & holes & ~r_hit_ok) : 8'h00;
  assign w_bad   = w_in_play ? (w_kedge & ~holes) : 8'h00;
  assign w_acc_n = popcnt8(w_acc);
  assign w_bad_n = popcnt8(w_bad);

  assign w_lvl_sum  = r_lvl_cnt + {3'd0, w_acc_n};
  assign w_lvl_wrap = (w_lvl_sum >= STEP_W);
  assign w_hsum     = {1'b0, r_base} + {1'b0, r_lvl};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_time    <= 6'd0;
      r_gen_clr <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_state <= ST_READY;
            r_time  <= READY_T;
          end
        end
        ST_READY: begin
          if (sec_tick) begin
            if (r_time <= 6'd1) begin
              r_state   <= ST_PLAY;
              r_time    <= GAME_T;
              r_gen_clr <= 1'b0;
            end else begin
              r_time <= r_time - 6'd1;
            end
          end
        end
        ST_PLAY: begin
          if (sec_tick) begin
            if (r_time <= 6'd1) begin
              r_state   <= ST_OVER;
              r_time    <= 6'd0;
              r_gen_clr <= 1'b1;
            end else begin
              r_time <= r_time - 6'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gen_clr <= 1'b1;
        end
      endcase
    end
  end

  // hit_ok is forced to zero on the PLAY exit edge so OVER never shows stale hits.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_keys_q <= 8'h00;
      r_hit_ok <= 8'h00;
    end else begin
      r_keys_q <= keys;
      if (!w_in_play || w_play_end) begin
        r_hit_ok <= 8'h00;
      end else begin
        r_hit_ok <= (r_hit_ok & holes) | w_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_base    <= 4'd0;
      r_lvl     <= 4'd0;
      r_lvl_cnt <= 7'd0;
      r_hrdn    <= 4'd0;
    end else begin
      r_hrdn <= (w_hsum > {1'b0, HRDN_MAX}) ? HRDN_MAX : w_hsum[3:0];
      if (w_to_ready) begin
        r_base    <= hrdn_sel;
        r_lvl     <= 4'd0;
        r_lvl_cnt <= 7'd0;
      end else begin
        r_lvl_cnt <= w_lvl_sum % STEP_W;
        if (w_lvl_wrap && (r_lvl != 4'hF)) begin
          r_lvl <= r_lvl + 4'd1;
        end
      end
    end
  end

  wam_bcd_acc u_score (
    .clk   (clk),
    .clr_n (clr_n),
    .i_clr (w_to_ready),
    .i_add (w_acc_n),
    .o_val (score)
  );

  wam_bcd_acc u_miss (
    .clk   (clk),
    .clr_n (clr_n),
    .i_clr (w_to_ready),
    .i_add (w_bad_n),
    .o_val (miss)
  );

  assign gen_clr   = r_gen_clr;
  assign hrdn      = r_hrdn;
  assign hit_ok    = r_hit_ok;
  assign time_left = r_time;
  assign state     = r_state;

endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl with an expected-value queue checked against DUT outputs.
module tb_wam_ctl;

  logic       clk;
  logic       clr_n;
  logic       sec_tick;
  logic       start;
  logic [3:0] hrdn_sel;
  logic [7:0] keys;
  logic [7:0] holes;
  logic       gen_clr;
  logic [3:0] hrdn;
  logic [7:0] hit_ok;
  logic [7:0] score;
  logic [7:0] miss;
  logic [5:0] time_left;
  logic [1:0] state;

  wam_ctl #(.GAME_SEC(30), .READY_SEC(3), .LVL_STEP(10)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .sec_tick  (sec_tick),
    .start     (start),
    .hrdn_sel  (hrdn_sel),
    .keys      (keys),
    .holes     (holes),
    .gen_clr   (gen_clr),
    .hrdn      (hrdn),
    .hit_ok    (hit_ok),
    .score     (score),
    .miss      (miss),
    .time_left (time_left),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the scoring/difficulty path.
  int sc_m  = 0;
  int lc_m  = 0;
  int lv_m  = 0;
  int base_m = 13;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int hrdn_m();
    return (base_m + lv_m > 15) ? 15 : base_m + lv_m;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present a fresh set of moles and hit all of them, then check score and hrdn.
  task automatic batch(input logic [7:0] m);
    int pc;
    holes = 8'h00;
    keys  = 8'h00;
    step();
    holes = m;
    keys  = m;
    pc = $countones(m);
    sc_m = (sc_m + pc > 99) ? 99 : sc_m + pc;
    lc_m = lc_m + pc;
    if (lc_m >= 10) begin
      lc_m = lc_m % 10;
      lv_m = lv_m + 1;
    end
    push("batch_score", 32'(to_bcd(sc_m)));
    step();
    chk(32'(score));
    push("batch_hrdn", 32'(hrdn_m()));
    step();
    chk(32'(hrdn));
  endtask

  task automatic check_reset_outputs(input string pfx);
    push({pfx, "_state"}, 32'd0);     chk(32'(state));
    push({pfx, "_gen_clr"}, 32'd1);   chk(32'(gen_clr));
    push({pfx, "_hrdn"}, 32'd0);      chk(32'(hrdn));
    push({pfx, "_hit_ok"}, 32'd0);    chk(32'(hit_ok));
    push({pfx, "_score"}, 32'd0);     chk(32'(score));
    push({pfx, "_miss"}, 32'd0);      chk(32'(miss));
    push({pfx, "_time"}, 32'd0);      chk(32'(time_left));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n    = 1'b0;
    sec_tick = 1'b0;
    start    = 1'b0;
    hrdn_sel = 4'd0;
    keys     = 8'h00;
    holes    = 8'h00;
    step();
    step();
    check_reset_outputs("rst");
    clr_n = 1'b1;
    step();

    // Start and countdown.
    hrdn_sel = 4'd13;
    pulse_start();
    hrdn_sel = 4'd0;
    push("ready_state", 32'd1);  chk(32'(state));
    push("ready_time3", 32'd3);  chk(32'(time_left));
    step();
    push("base_hrdn", 32'd13);   chk(32'(hrdn));
    tick();
    push("ready_time2", 32'd2);  chk(32'(time_left));
    tick();
    push("ready_time1", 32'd1);  chk(32'(time_left));
    push("ready_genclr", 32'd1); chk(32'(gen_clr));
    tick();
    push("play_state", 32'd2);   chk(32'(state));
    push("play_time", 32'd30);   chk(32'(time_left));
    push("play_genclr", 32'd0);  chk(32'(gen_clr));

    // One hit on hole 3, then that mole leaves.
    holes = 8'h08;
    keys  = 8'h08;
    sc_m = 1; lc_m = 1;
    step();
    push("hit1_hit_ok", 32'h08); chk(32'(hit_ok));
    push("hit1_score", 32'h01);  chk(32'(score));
    holes = 8'h05;
    keys  = 8'h00;
    step();
    push("hole3_clear", 32'h00); chk(32'(hit_ok));

    // Edge on keys 0..2 with moles on 0 and 2: two hits and one miss.
    keys = 8'h07;
    sc_m = 3; lc_m = 3;
    step();
    push("hit2_hit_ok", 32'h05); chk(32'(hit_ok));
    push("hit2_score", 32'h03);  chk(32'(score));
    push("hit2_miss", 32'h01);   chk(32'(miss));
    holes = 8'h04;
    step();
    push("hole0_clear", 32'h04); chk(32'(hit_ok));

    // Re-press on a hole already hit: neither hit nor miss.
    keys = 8'h03;
    step();
    keys = 8'h07;
    step();
    push("rehit_score", 32'h03); chk(32'(score));
    push("rehit_miss", 32'h01);  chk(32'(miss));

    // Difficulty ramp and score saturation.
    batch(8'h7F);
    batch(8'hFF);
    batch(8'h03);
    batch(8'hFF);
    batch(8'h03);
    for (int i = 0; i < 8; i++) batch(8'hFF);
    batch(8'h0F);
    push("score98", 32'h98);     chk(32'(score));
    batch(8'h07);
    batch(8'hFF);
    push("miss_kept", 32'h01);   chk(32'(miss));

    // A live hit going into the end of the round.
    holes = 8'h01;
    keys  = 8'h00;
    step();
    keys = 8'h01;
    step();
    push("final_hit_ok", 32'h01); chk(32'(hit_ok));
    for (int i = 0; i < 29; i++) tick();
    push("play_time1", 32'd1);   chk(32'(time_left));
    push("play_still", 32'd2);   chk(32'(state));
    tick();
    push("over_state", 32'd3);   chk(32'(state));
    push("over_genclr", 32'd1);  chk(32'(gen_clr));
    push("over_hit_ok", 32'h00); chk(32'(hit_ok));
    push("over_score", 32'h99);  chk(32'(score));
    push("over_time", 32'd0);    chk(32'(time_left));
    keys  = 8'h00;
    holes = 8'h01;
    step();
    keys = 8'h03;
    step();
    tick();
    push("over_ign_score", 32'h99); chk(32'(score));
    push("over_ign_miss", 32'h01);  chk(32'(miss));
    push("over_ign_hit", 32'h00);   chk(32'(hit_ok));
    push("over_ign_state", 32'd3);  chk(32'(state));

    // Restart from OVER clears the counters.
    pulse_start();
    push("restart_state", 32'd1);  chk(32'(state));
    push("restart_score", 32'h00); chk(32'(score));
    push("restart_miss", 32'h00);  chk(32'(miss));
    push("restart_time", 32'd3);   chk(32'(time_left));
    tick();
    tick();
    tick();
    push("replay_state", 32'd2);   chk(32'(state));
    holes = 8'h01;
    keys  = 8'h00;
    step();
    keys = 8'h01;
    step();
    push("replay_score", 32'h01);  chk(32'(score));

    // Asynchronous reset mid-PLAY with every key held.
    keys  = 8'hFF;
    clr_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    step();
    clr_n = 1'b1;
    step();
    pulse_start();
    tick();
    tick();
    tick();
    holes = 8'h0F;
    step();
    step();
    push("post_state", 32'd2);     chk(32'(state));
    push("post_score", 32'h00);    chk(32'(score));
    push("post_miss", 32'h00);     chk(32'(miss));
    push("post_hit_ok", 32'h00);   chk(32'(hit_ok));
    push("post_hrdn", 32'd0);      chk(32'(hrdn));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
